// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Front-end fetch stage. Generates the program counter, issues one 32-bit
// instruction read per request to the instruction memory, and presents a
// latched instruction to decode. A one-bit epoch tags every request so that
// responses to requests made before a redirect are discarded on arrival.
//
// Parameters:
//   RESET_PC         first fetch address after reset (4-byte aligned)
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   stall_in         decode cannot accept; decode-facing outputs hold
//   redirect_valid   execute requests a PC change this cycle
//   redirect_pc      new fetch address, bits [1:0] ignored
//   halt             stop issuing requests until redirect or reset
//   imem_req_*       read request (valid/ready handshake, word address)
//   imem_resp_*      in-order read response (data valid, instruction word)
//   pc_output_valid  instruction / instruction_pc are live
//   instruction      latched instruction word
//   instruction_pc   latched address of instruction
//
// Configuration:
//   INSTRUCTION_FETCH_SKID_EN  adds a one-entry skid buffer so fetch keeps
//                              requesting while decode is stalled, giving one
//                              instruction per cycle with 1-cycle memory.
// -----------------------------------------------------------------------------
module instruction_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        halt,
    output logic        imem_req_valid,
    output logic [63:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        pc_output_valid,
    output logic [31:0] instruction,
    output logic [63:0] instruction_pc
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HALTED} state_e;

    state_e      state_q, state_d;
    logic [63:0] fetch_pc_q, fetch_pc_d;
    logic        epoch_q, epoch_d;
    logic [1:0]  outstanding_q, outstanding_d;
    logic        tag_epoch_q, tag_epoch_d;
    logic [63:0] tag_pc_q, tag_pc_d;
    logic        pc_output_valid_q, pc_output_valid_d;
    logic [31:0] instruction_q, instruction_d;
    logic [63:0] instruction_pc_q, instruction_pc_d;

`ifdef INSTRUCTION_FETCH_SKID_EN
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_data_q, skid_data_d;
    logic [63:0] skid_pc_q, skid_pc_d;
    logic        req_pending_q, req_pending_d;
    logic [1:0]  out_after;
`endif

    logic req_valid;
    logic accept;
    logic resp_take;
    logic resp_live;

    // Redirect targets are forced word-aligned; the low bits carry no meaning.
    logic unused_redirect_bits;
    assign unused_redirect_bits = ^redirect_pc[1:0];

    always_comb begin
        // NOTE: every _d starts as its _q so no branch can leave a latch behind.
        state_d           = state_q;
        fetch_pc_d        = fetch_pc_q;
        epoch_d           = epoch_q;
        tag_epoch_d       = tag_epoch_q;
        tag_pc_d          = tag_pc_q;
        instruction_d     = instruction_q;
        instruction_pc_d  = instruction_pc_q;
        // Valid is a one-cycle offer: it survives only while decode stalls.
        pc_output_valid_d = pc_output_valid_q && stall_in;

        // Responses only count against requests issued since the last reset.
        resp_take = imem_resp_valid && (outstanding_q != 2'd0);
        resp_live = resp_take && (tag_epoch_q == epoch_q) && (state_q != HALTED)
                    && !halt && !redirect_valid;

`ifdef INSTRUCTION_FETCH_SKID_EN
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_pc_d    = skid_pc_q;
        out_after    = outstanding_q - {1'b0, resp_take};

        // A parked word always goes to decode ahead of a fresh response.
        if (!stall_in && skid_valid_q) begin
            pc_output_valid_d = 1'b1;
            instruction_d     = skid_data_q;
            instruction_pc_d  = skid_pc_q;
            skid_valid_d      = 1'b0;
        end
        if (resp_live) begin
            if (!stall_in && !skid_valid_q) begin
                pc_output_valid_d = 1'b1;
                instruction_d     = imem_resp_data;
                instruction_pc_d  = tag_pc_q;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = imem_resp_data;
                skid_pc_d    = tag_pc_q;
            end
        end

        // Issue only when the eventual response is guaranteed a landing slot
        // even if decode stalls; a request already shown is held until taken.
        req_valid = (state_q == REQ) && !redirect_valid && !halt
                    && (req_pending_q || ((out_after == 2'd0) && !skid_valid_d));
`else
        req_valid = (state_q == REQ);
`endif

        accept        = req_valid && imem_req_ready;
        outstanding_d = outstanding_q + {1'b0, accept} - {1'b0, resp_take};
        if (accept) begin
            tag_epoch_d = epoch_q;
            tag_pc_d    = fetch_pc_q;
            fetch_pc_d  = fetch_pc_q + 64'd4;
        end

`ifdef INSTRUCTION_FETCH_SKID_EN
        req_pending_d = req_valid && !imem_req_ready;
        if (state_q == IDLE || state_q == WAIT) begin
            state_d = REQ;
        end
`else
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (accept) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (resp_take) begin
                    if (resp_live && !stall_in) begin
                        pc_output_valid_d = 1'b1;
                        instruction_d     = imem_resp_data;
                        instruction_pc_d  = tag_pc_q;
                        state_d           = REQ;
                    end else if (resp_live) begin
                        // Nowhere to hold the word: refetch it once decode frees up.
                        fetch_pc_d = tag_pc_q;
                    end else begin
                        state_d = REQ;
                    end
                end else if ((outstanding_q == 2'd0) && !stall_in) begin
                    state_d = REQ;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
        endcase
`endif

        // Redirect outranks everything; halt outranks stall and response.
        if (redirect_valid) begin
            fetch_pc_d        = {redirect_pc[63:2], 2'b00};
            epoch_d           = ~epoch_q;
            pc_output_valid_d = 1'b0;
`ifdef INSTRUCTION_FETCH_SKID_EN
            skid_valid_d = 1'b0;
            state_d      = REQ;
`else
            // Drain a wrong-path response before the single slot is reused.
            state_d = (outstanding_d != 2'd0) ? WAIT : REQ;
`endif
        end else if (halt) begin
            state_d           = HALTED;
            pc_output_valid_d = 1'b0;
`ifdef INSTRUCTION_FETCH_SKID_EN
            skid_valid_d = 1'b0;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: datapath registers are reset too, so decode sees a defined NOP.
            state_q           <= IDLE;
            fetch_pc_q        <= RESET_PC;
            epoch_q           <= 1'b0;
            outstanding_q     <= 2'd0;
            tag_epoch_q       <= 1'b0;
            tag_pc_q          <= RESET_PC;
            pc_output_valid_q <= 1'b0;
            instruction_q     <= NOP;
            instruction_pc_q  <= RESET_PC;
`ifdef INSTRUCTION_FETCH_SKID_EN
            skid_valid_q  <= 1'b0;
            skid_data_q   <= NOP;
            skid_pc_q     <= RESET_PC;
            req_pending_q <= 1'b0;
`endif
        end else begin
            state_q           <= state_d;
            fetch_pc_q        <= fetch_pc_d;
            epoch_q           <= epoch_d;
            outstanding_q     <= outstanding_d;
            tag_epoch_q       <= tag_epoch_d;
            tag_pc_q          <= tag_pc_d;
            pc_output_valid_q <= pc_output_valid_d;
            instruction_q     <= instruction_d;
            instruction_pc_q  <= instruction_pc_d;
`ifdef INSTRUCTION_FETCH_SKID_EN
            skid_valid_q  <= skid_valid_d;
            skid_data_q   <= skid_data_d;
            skid_pc_q     <= skid_pc_d;
            req_pending_q <= req_pending_d;
`endif
        end
    end

    assign imem_req_valid  = req_valid;
    assign imem_req_addr   = fetch_pc_q;
    assign pc_output_valid = pc_output_valid_q;
    assign instruction     = instruction_q;
    assign instruction_pc  = instruction_pc_q;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Front-end pipeline stage: generates the program counter, issues one instruction-word read to the instruction memory port, and presents latched `pc_output_valid`/`instruction`/`instruction_pc` to the decode stage. It honours the decode stage's `stall_out` (received here as `stall_in`) and accepts a PC redirect from execute for taken branches, jumps and FENCE.I. Stale memory responses are discarded with an epoch bit so that redirects never leak wrong-path instructions.

## Interface
Parameters:
- `RESET_PC`, default 64'h0: first fetch address after reset; must be 4-byte aligned.

Ports. One clock; reset is synchronous and active-high (`clk`, `rst`).
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `stall_in`  in  1  decode cannot accept; fetch outputs must hold.
- `redirect_valid`  in  1  execute requests a PC change this cycle.
- `redirect_pc`  in  64  new fetch address; bits [1:0] ignored (treated as 0).
- `halt`  in  1  final instruction retired; stop issuing requests.
- `imem_req_valid`  out  1  read request.
- `imem_req_addr`  out  64  word-aligned read address.
- `imem_req_ready`  in  1  memory accepts the request when high with valid.
- `imem_resp_valid`  in  1  read data valid (in order, at least 1 cycle after acceptance).
- `imem_resp_data`  in  32  instruction word.
- `pc_output_valid`  out  1  latched: instruction/instruction_pc are live.
- `instruction`  out  32  latched instruction word.
- `instruction_pc`  out  64  latched address of `instruction`.

## Operation
- State: `fetch_pc` (next address to request), `epoch` (1 bit), `outstanding` (count 0..1, or 0..2 with the skid feature), FSM {`IDLE`, `REQ`, `WAIT`, `HALTED`}.
- `IDLE`: entered on reset; leaves to `REQ` the next cycle.
- `REQ`: `imem_req_valid`=1, `imem_req_addr`=`fetch_pc`. On `imem_req_ready`: tag the request with the current `epoch` and `fetch_pc`, set `fetch_pc` += 4 (mod 2^64, wraps to 0), go to `WAIT`.
- `WAIT`: on `imem_resp_valid` with matching tag epoch, if `stall_in`=0 latch `instruction`/`instruction_pc`, set `pc_output_valid`=1, return to `REQ`. If the tag epoch is stale, drop the response and return to `REQ`.
- No new request is issued while `stall_in`=1 and a fetched instruction is waiting to be consumed, except under the skid configuration.
- `stall_in`=1: all three decode-facing outputs hold their values exactly.
- Redirect (`redirect_valid`=1): `fetch_pc` <= {`redirect_pc`[63:2],2'b00}; `epoch` toggles; `pc_output_valid` <= 0 next cycle regardless of `stall_in`. Any outstanding response is dropped on arrival. A request being accepted in the same cycle is tagged with the old epoch and is dropped. Redirect has priority over stall, halt and response.
- `halt`=1: go to `HALTED`; no further requests; an outstanding response is dropped; `pc_output_valid` <= 0. A subsequent redirect leaves `HALTED` for `REQ`. Only `rst` and redirect exit `HALTED`.
- `rst` mid-operation: FSM to `IDLE`, `fetch_pc`=RESET_PC, `epoch`=0, `outstanding`=0. A response arriving after reset for a pre-reset request is dropped via the outstanding count.

## Timing
- Reset values: `pc_output_valid`=0, `imem_req_valid`=0, `imem_req_addr`=RESET_PC, `instruction`=32'h00000013 (NOP), `instruction_pc`=RESET_PC.
- First request is asserted 1 cycle after `rst` deasserts.
- A response in cycle N (not stalled) gives `pc_output_valid`=1 in cycle N+1.
- With 1-cycle memory latency, throughput is one instruction every 2 cycles without the skid configuration.
- A redirect in cycle N gives `pc_output_valid`=0 in N+1, and a request to `redirect_pc` no earlier than N+1.
- `imem_req_valid` once asserted stays high with a stable address until ready, unless a redirect or `rst` occurs.

## Configuration
- `INSTRUCTION_FETCH_SKID_EN` defined: adds a 1-entry skid buffer and permits 2 outstanding requests. Fetch keeps requesting while `stall_in`=1, parking the returned word in the skid buffer (epoch-checked; a redirect clears it). When the stall releases, the skid entry is presented the next cycle, and back-to-back issue gives 1 instruction/cycle at 1-cycle latency.
- Not defined: no skid buffer, at most 1 outstanding request, behaviour exactly as in Operation.

## Test plan
- Reset, RESET_PC=64'h1000, memory latency 1 -> requests at 0x1000, 0x1004, 0x1008; outputs show matching PCs/words, valid every 2nd cycle (every cycle with skid).
- Hold `stall_in`=1 for 5 cycles while an instruction at 0x1004 is live -> outputs unchanged for all 5 cycles; next PC is 0x1008 after release.
- Redirect to 0x2002 while a response for 0x1008 is outstanding -> 0x1008 never appears, next valid PC is 0x2000, `pc_output_valid`=0 the cycle after the redirect.
- Redirect while `stall_in`=1 -> `pc_output_valid`=0 next cycle; fetch resumes at the target.
- `fetch_pc`=64'hFFFF_FFFF_FFFF_FFFC -> next request address is 0.
- `halt` asserted, then 10 idle cycles -> no `imem_req_valid`; redirect to 0x40 -> fetch resumes at 0x40.
